// File: rtl/gps_pkg.sv
// ---------------------------------------------------------------------------
// gps_pkg
// Shared constants for the GPS distance back end (asin stage and its divider).
//   GPS_DIAM       Earth diameter 2R in whole metres
//   FRAC_A         fraction bits of the haversine term a, of sqrt(a) and of asin
//   FRAC_D         fraction bits of the emitted distance D
//   GPS_ADDR_W     ASIN table address width
//   GPS_LAST_ADDR  highest ASIN table index searched
//   state_t/ST_*   controller states of gps_dist_asin
// ---------------------------------------------------------------------------
package gps_pkg;

    localparam logic [23:0] GPS_DIAM      = 24'd12756274;
    localparam int          FRAC_A        = 64;
    localparam int          FRAC_D        = 8;
    localparam int          GPS_ADDR_W    = 6;
    localparam logic [5:0]  GPS_LAST_ADDR = 6'd63;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SQRT   = 3'd1;
    localparam state_t ST_SEARCH = 3'd2;
    localparam state_t ST_INTERP = 3'd3;
    localparam state_t ST_DIV    = 3'd4;
    localparam state_t ST_SCALE  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

endpackage

// File: rtl/gps_serial_div.sv
// ---------------------------------------------------------------------------
// gps_serial_div
// Restoring divider, 128-bit numerator by 64-bit denominator, 64-bit quotient,
// one quotient bit per cycle (64 cycles). The caller guarantees
// i_num[127:64] < i_den so the quotient fits in 64 bits. A zero denominator
// yields a zero quotient.
//   clk, reset_n   clock, asynchronous active-low reset
//   i_start        load i_num/i_den and begin (ignored while busy)
//   i_num, i_den   operands
//   o_busy         iterations in progress
//   o_done         one-cycle pulse the cycle after the last iteration
//   o_q            quotient, valid from o_done until the next start
// ---------------------------------------------------------------------------
module gps_serial_div
    import gps_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [2*FRAC_A-1:0]   i_num,
    input  logic [FRAC_A-1:0]     i_den,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [FRAC_A-1:0]     o_q
);

    logic [FRAC_A-1:0] r_rem;
    logic [FRAC_A-1:0] r_q;        // low numerator bits shift out, quotient bits shift in
    logic [FRAC_A-1:0] r_den;
    logic [5:0]        r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_den_zero;

    logic [FRAC_A:0]   w_sh;
    logic              w_ge;

    assign w_sh = {r_rem, r_q[FRAC_A-1]};
    assign w_ge = (w_sh >= {1'b0, r_den});

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem      <= '0;
            r_q        <= '0;
            r_den      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_den_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_rem      <= i_num[2*FRAC_A-1:FRAC_A];
                r_q        <= i_num[FRAC_A-1:0];
                r_den      <= i_den;
                r_den_zero <= (i_den == '0);
                r_cnt      <= '0;
                r_busy     <= 1'b1;
            end else if (r_busy) begin
                // When w_sh[64] is set the subtraction always succeeds, so the
                // restore path only ever sees a 64-bit partial remainder.
                if (w_ge) r_rem <= FRAC_A'(w_sh - {1'b0, r_den});
                else      r_rem <= w_sh[FRAC_A-1:0];
                r_q   <= {r_q[FRAC_A-2:0], w_ge};
                r_cnt <= r_cnt + 6'd1;
                if (r_cnt == 6'd63) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_q    = r_den_zero ? '0 : r_q;

endmodule

// File: rtl/gps_dist_asin.sv
// ---------------------------------------------------------------------------
// gps_dist_asin
// Back end of the GPS distance calculator: D = 2R * asin(sqrt(a)).
// Bit-serial square root, linear search of the external ASIN table, linear
// interpolation through gps_serial_div, then scaling by the Earth diameter.
//   clk, reset_n   clock, asynchronous active-low reset
//   a_valid, a_in  haversine term a (UQ0.64) offered by the upstream stage
//   a_ready        high only while idle; a_valid && a_ready accepts a_in
//   ASIN_ADDR      registered table address
//   ASIN_DATA      same-cycle table read: [127:64] x (UQ0.64), [63:0] asin(x)
//   d_valid        one-cycle pulse when D is updated
//   D              distance in metres, UQ32.8, held until the next result
// ---------------------------------------------------------------------------
module gps_dist_asin
    import gps_pkg::*;
#(
    parameter logic [23:0]        DIAM      = GPS_DIAM,
    parameter int                 ADDR_W    = GPS_ADDR_W,
    parameter logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GPS_LAST_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_valid,
    input  logic [FRAC_A-1:0]     a_in,
    output logic                  a_ready,
    output logic [ADDR_W-1:0]     ASIN_ADDR,
    input  logic [2*FRAC_A-1:0]   ASIN_DATA,
    output logic                  d_valid,
    output logic [31+FRAC_D:0]    D
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [127:0]        r_rad;     // radicand {a, 64'd0}, consumed two bits per cycle
    logic [65:0]         r_rem;     // sqrt partial remainder, never exceeds 2*root
    logic [FRAC_A-1:0]   r_root;    // holds s once the square root finishes
    logic [5:0]          r_cnt;
    logic [FRAC_A-1:0]   r_x0;
    logic [FRAC_A-1:0]   r_y0;
    logic [FRAC_A-1:0]   r_y;
    logic                r_clamp;   // s beyond the last table x: use y0 as is
    logic                r_d_valid;
    logic [31+FRAC_D:0]  r_d;

    logic [FRAC_A-1:0]   w_x;
    logic [FRAC_A-1:0]   w_y;
    logic [67:0]         w_rem_sh;
    logic [67:0]         w_trial;
    logic                w_rem_ge;
    logic [2*FRAC_A-1:0] w_num;
    logic [FRAC_A-1:0]   w_den;
    logic                w_div_start;
    logic                w_div_busy;
    logic                w_div_done;
    logic [FRAC_A-1:0]   w_div_q;
    logic [FRAC_A-1:0]   w_y_sel;

    assign w_x = ASIN_DATA[2*FRAC_A-1:FRAC_A];
    assign w_y = ASIN_DATA[FRAC_A-1:0];

    // Restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1.
    assign w_rem_sh = {r_rem, r_rad[127:126]};
    assign w_trial  = {2'b00, r_root, 2'b01};
    assign w_rem_ge = (w_rem_sh >= w_trial);

    // Interpolation operands; ASIN_ADDR holds the first entry with x >= s here,
    // so ASIN_DATA is (x1, y1) and (x0, y0) is the entry before it.
    assign w_num       = {64'd0, FRAC_A'(r_root - r_x0)} * {64'd0, FRAC_A'(w_y - r_y0)};
    assign w_den       = w_x - r_x0;
    assign w_div_start = (r_state == ST_INTERP) && (r_addr != '0);
    assign w_y_sel     = r_clamp ? r_y0 : r_y;

    gps_serial_div u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_div_start),
        .i_num   (w_num),
        .i_den   (w_den),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_q     (w_div_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_y       <= '0;
            r_clamp   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d       <= '0;
        end else begin
            r_d_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (a_valid && a_ready) begin
                        r_rad   <= {a_in, 64'd0};
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_x0    <= '0;
                        r_y0    <= '0;
                        r_y     <= '0;
                        r_clamp <= 1'b0;
                        r_state <= ST_SQRT;
                    end
                end
                ST_SQRT: begin
                    r_rad <= r_rad << 2;
                    if (w_rem_ge) begin
                        r_rem  <= 66'(w_rem_sh - w_trial);
                        r_root <= {r_root[FRAC_A-2:0], 1'b1};
                    end else begin
                        r_rem  <= 66'(w_rem_sh);
                        r_root <= {r_root[FRAC_A-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) r_state <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (w_x >= r_root) begin
                        r_state <= ST_INTERP;
                    end else begin
                        r_x0 <= w_x;
                        r_y0 <= w_y;
                        if (r_addr == LAST_ADDR) begin
                            r_clamp <= 1'b1;
                            r_state <= ST_SCALE;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                ST_INTERP: begin
                    // Only s == 0 stops at entry 0, and there y1 is the answer.
                    if (r_addr == '0) begin
                        r_y     <= w_y;
                        r_state <= ST_SCALE;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_y     <= r_y0 + w_div_q;
                        r_state <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    // y * DIAM is UQ24.64 metres; keep 32 integer and 8 fraction bits.
                    r_d       <= 40'(({32'd0, w_y_sel} * {72'd0, DIAM}) >> (FRAC_A - FRAC_D));
                    r_d_valid <= 1'b1;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The divider is always idle in ST_IDLE; the extra term keeps a stray
    // divide from overlapping a fresh job.
    assign a_ready   = (r_state == ST_IDLE) && !w_div_busy;
    assign ASIN_ADDR = r_addr;
    assign d_valid   = r_d_valid;
    assign D         = r_d;

endmodule

// File: tb/tb_gps_dist_asin.sv
// ---------------------------------------------------------------------------
// tb_gps_dist_asin
// Directed bench for gps_dist_asin against an identity ASIN table
// (x_i = y_i = i * 2^58). Expected distances and latencies are hand-derived.
// ---------------------------------------------------------------------------
module tb_gps_dist_asin;

    localparam logic [63:0] A_QTR   = 64'h4000_0000_0000_0000;  // 0.25 -> s = 2^63
    localparam logic [63:0] A_MID   = 64'h4101_0000_0000_0000;  // s = 2^63 + 2^56
    localparam logic [63:0] A_MAX   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [39:0] D_QTR   = 40'h0061529900;           // 6378137.0 m
    localparam logic [39:0] D_MID   = 40'd1645559346;           // DIAM * 129
    localparam logic [39:0] D_CLAMP = 40'd3214581048;           // DIAM * 252

    logic         clk = 1'b0;
    logic         reset_n;
    logic         a_valid;
    logic [63:0]  a_in;
    logic         a_ready;
    logic [5:0]   ASIN_ADDR;
    logic [127:0] ASIN_DATA;
    logic         d_valid;
    logic [39:0]  D;

    int n_checks = 0;
    int n_pass   = 0;

    gps_dist_asin dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_in      (a_in),
        .a_ready   (a_ready),
        .ASIN_ADDR (ASIN_ADDR),
        .ASIN_DATA (ASIN_DATA),
        .d_valid   (d_valid),
        .D         (D)
    );

    always #5 clk = ~clk;

    always_comb ASIN_DATA = {ASIN_ADDR, 58'd0, ASIN_ADDR, 58'd0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Start at a negedge with the DUT idle; lat counts the accept cycle through
    // the d_valid cycle inclusive.
    task automatic run_job(input string tag, input logic [63:0] a,
                           input logic [39:0] exp_d, output int lat);
        int n;
        a_in    = a;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        n = 1;
        while (!d_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_dvalid"}, 64'(d_valid), 64'd1);
        check({tag, "_D"}, 64'(D), 64'(exp_d));
        lat = n + 1;
        @(negedge clk);
        check({tag, "_pulse"}, 64'(d_valid), 64'd0);
        check({tag, "_ready"}, 64'(a_ready), 64'd1);
        check({tag, "_hold"}, 64'(D), 64'(exp_d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int pulses;
        bit drop_next;

        reset_n = 1'b0;
        a_valid = 1'b0;
        a_in    = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(a_ready), 64'd1);
        check("rst_dvalid", 64'(d_valid), 64'd0);
        check("rst_D", 64'(D), 64'd0);
        check("rst_addr", 64'(ASIN_ADDR), 64'd0);

        // Exact hit at entry 32 through the full divide path.
        run_job("qtr", A_QTR, D_QTR, lat);
        check("qtr_lat", 64'(lat), 64'd166);
        check("qtr_addr", 64'(ASIN_ADDR), 64'd32);

        // s = 0 stops at entry 0.
        run_job("zero", 64'd0, 40'd0, lat);
        check("zero_addr", 64'(ASIN_ADDR), 64'd0);

        // Between entries 32 and 33: interpolation plus divide.
        run_job("mid", A_MID, D_MID, lat);
        check("mid_lat", 64'(lat), 64'd167);
        check("mid_addr", 64'(ASIN_ADDR), 64'd33);

        // Beyond the last entry: clamp to y_63, no divide.
        run_job("clamp", A_MAX, D_CLAMP, lat);
        check("clamp_addr", 64'(ASIN_ADDR), 64'd63);
        check("clamp_nodiv", 64'(lat < 140), 64'd1);

        // Back-to-back with a_valid held, plus ignored pulses while busy.
        pulses    = 0;
        drop_next = 1'b0;
        a_in      = 64'd0;
        a_valid   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (d_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("b2b_d1", 64'(D), 64'd0);
                    check("b2b_done_ready", 64'(a_ready), 64'd0);
                end else begin
                    check("b2b_d2", 64'(D), 64'(D_MID));
                end
            end
            if (drop_next) begin
                check("b2b_accept2", 64'(a_ready), 64'd0);
                a_valid   = 1'b0;
                drop_next = 1'b0;
            end else if (pulses == 1 && a_valid && a_ready) begin
                drop_next = 1'b1;
            end
            if (i == 8) a_in = A_MAX;
            if (i >= 10 && i < 20) a_valid = i[0];
            if (i == 20) begin
                a_in    = A_MID;
                a_valid = 1'b1;
            end
        end
        check("b2b_pulses", 64'(pulses), 64'd2);

        // Reset during the divide phase, then a clean job.
        a_in    = A_MID;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (120) @(negedge clk);
        check("midop_addr", 64'(ASIN_ADDR), 64'd33);
        check("midop_busy", 64'(a_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("midop_rst_D", 64'(D), 64'd0);
        check("midop_rst_dvalid", 64'(d_valid), 64'd0);
        check("midop_rst_addr", 64'(ASIN_ADDR), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(a_ready), 64'd1);
        run_job("post_rst", A_QTR, D_QTR, lat);
        check("post_rst_lat", 64'(lat), 64'd166);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
